probe_capture: RTL and testbench

Front-end capture stage for the hardware monitor: takes eight synchronous 8-bit probe channels and produces the eight held byte values that the LCD renderer draws. It rate-limits updates to a human-readable period, supports a pattern trigger with hold-off, and a debounced freeze button. Outputs connect directly to the renderer's `in_0`..`in_7`.

---
 rtl/monitor_pkg.sv | 23 ++
 rtl/debounce.sv | 46 ++++
 rtl/probe_capture.sv | 140 ++++++++++++++
 tb/tb_probe_capture.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/monitor_pkg.sv
// Shared definitions for the hardware monitor: channel geometry and capture FSM states.
// The LCD renderer sizes its inputs from the same CH_COUNT/CH_WIDTH.
package monitor_pkg;

  localparam int CH_COUNT = 8;
  localparam int CH_WIDTH = 8;
  localparam int CH_SEL_W = $clog2(CH_COUNT);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_ARMED  = 2'b01,
    ST_HOLD   = 2'b10,
    ST_FROZEN = 2'b11
  } state_t;

  function automatic logic [CH_WIDTH-1:0] channel_of(
    input logic [CH_COUNT*CH_WIDTH-1:0] bus,
    input logic [CH_SEL_W-1:0]          idx
  );
    return bus[idx*CH_WIDTH +: CH_WIDTH];
  endfunction

endpackage

// File: rtl/debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter, and a one-cycle
// pulse on each accepted press (stable 1->0). Releases are accepted silently.
module debounce #(
  parameter int DEBOUNCE = 270000
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw,
  output logic press_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             stable_reg;
  logic             pulse_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_reg  <= 1'b1;
      sync2_reg  <= 1'b1;
      stable_reg <= 1'b1;
      pulse_reg  <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      pulse_reg <= 1'b0;
      if (sync2_reg == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_W'(DEBOUNCE - 1)) begin
        // New level has held long enough; only a falling level is a press.
        stable_reg <= sync2_reg;
        cnt_reg    <= '0;
        pulse_reg  <= ~sync2_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign press_pulse = pulse_reg;

endmodule

// File: rtl/probe_capture.sv
// Capture front-end: registers eight probe channels and snapshots them either on a
// free-running divider or on a masked pattern trigger with hold-off; a button freezes it.
module probe_capture
  import monitor_pkg::*;
#(
  parameter int SAMPLE_DIV  = 540000,
  parameter int DEBOUNCE    = 270000,
  parameter int HOLD_CYCLES = 27000000
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [CH_COUNT*CH_WIDTH-1:0] probe,
  input  logic                         mode,
  input  logic [CH_SEL_W-1:0]          trig_ch,
  input  logic [CH_WIDTH-1:0]          trig_mask,
  input  logic [CH_WIDTH-1:0]          trig_value,
  input  logic                         freeze_btn,
  output logic [CH_WIDTH-1:0]          out_0,
  output logic [CH_WIDTH-1:0]          out_1,
  output logic [CH_WIDTH-1:0]          out_2,
  output logic [CH_WIDTH-1:0]          out_3,
  output logic [CH_WIDTH-1:0]          out_4,
  output logic [CH_WIDTH-1:0]          out_5,
  output logic [CH_WIDTH-1:0]          out_6,
  output logic [CH_WIDTH-1:0]          out_7,
  output logic [CH_COUNT-1:0]          changed,
  output logic                         snap_valid,
  output logic [1:0]                   state
);

  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  logic [CH_COUNT*CH_WIDTH-1:0] probe_q_reg;
  state_t                       state_reg, state_next;
  logic [DIV_W-1:0]             div_reg;
  logic [HOLD_W-1:0]            hold_reg;
  logic [CH_WIDTH-1:0]          out_reg [CH_COUNT];
  logic [CH_COUNT-1:0]          changed_reg, changed_next;
  logic                         snap_valid_reg;

  logic press, div_wrap, hold_done, trig_match, snap_en, div_clr;

  debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk        (clk),
    .resetn     (resetn),
    .raw        (freeze_btn),
    .press_pulse(press)
  );

  assign div_wrap   = (div_reg == DIV_W'(SAMPLE_DIV - 1));
  assign hold_done  = (hold_reg == HOLD_W'(HOLD_CYCLES - 1));
  assign trig_match = ((channel_of(probe_q_reg, trig_ch) ^ trig_value) & trig_mask) == '0;

  // A press outranks everything; a wrap or match outranks a mode change.
  always_comb begin
    state_next = state_reg;
    snap_en    = 1'b0;
    div_clr    = 1'b0;
    if (press) begin
      if (state_reg == ST_FROZEN) begin
        state_next = mode ? ST_ARMED : ST_RUN;
        div_clr    = 1'b1;
      end else begin
        state_next = ST_FROZEN;
      end
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (div_wrap)  snap_en    = 1'b1;
          else if (mode) state_next = ST_ARMED;
        end
        ST_ARMED: begin
          if (trig_match) begin
            snap_en    = 1'b1;
            state_next = ST_HOLD;
          end else if (!mode) begin
            state_next = ST_RUN;
            div_clr    = 1'b1;
          end
        end
        ST_HOLD: begin
          if (hold_done) begin
            state_next = mode ? ST_ARMED : ST_RUN;
            div_clr    = !mode;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      probe_q_reg <= '0;
      state_reg   <= ST_RUN;
      div_reg     <= '0;
      hold_reg    <= '0;
    end else begin
      probe_q_reg <= probe;
      state_reg   <= state_next;
      if (div_clr)                 div_reg <= '0;
      else if (state_reg == ST_RUN) div_reg <= div_wrap ? '0 : div_reg + 1'b1;
      // Hold counter idles at zero outside HOLD, so entering HOLD starts from 0.
      if (state_reg != ST_HOLD)    hold_reg <= '0;
      else if (!hold_done)         hold_reg <= hold_reg + 1'b1;
    end
  end

  for (genvar gi = 0; gi < CH_COUNT; gi++) begin : g_changed
    assign changed_next[gi] = (probe_q_reg[gi*CH_WIDTH +: CH_WIDTH] != out_reg[gi]);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < CH_COUNT; i++) out_reg[i] <= '0;
      changed_reg    <= '0;
      snap_valid_reg <= 1'b0;
    end else begin
      snap_valid_reg <= snap_en;
      if (snap_en) begin
        for (int i = 0; i < CH_COUNT; i++) out_reg[i] <= probe_q_reg[i*CH_WIDTH +: CH_WIDTH];
        changed_reg <= changed_next;
      end
    end
  end

  assign out_0      = out_reg[0];
  assign out_1      = out_reg[1];
  assign out_2      = out_reg[2];
  assign out_3      = out_reg[3];
  assign out_4      = out_reg[4];
  assign out_5      = out_reg[5];
  assign out_6      = out_reg[6];
  assign out_7      = out_reg[7];
  assign changed    = changed_reg;
  assign snap_valid = snap_valid_reg;
  assign state      = state_reg;

endmodule

// File: tb/tb_probe_capture.sv
// Scoreboard bench for probe_capture: stimulus queues expected snapshots, a monitor
// pops and compares them on every snap_valid pulse.
module tb_probe_capture;
  import monitor_pkg::*;

  localparam logic [63:0] P0 = 64'h0706_0504_0302_0100;
  localparam logic [63:0] P1 = 64'h0706_0504_035A_0100;
  localparam logic [63:0] P2 = 64'h0706_0504_03A7_0100;
  localparam logic [63:0] P3 = 64'h0711_2233_4455_6601;

  logic        clk = 1'b0;
  logic        resetn;
  logic [63:0] probe;
  logic        mode;
  logic [2:0]  trig_ch;
  logic [7:0]  trig_mask, trig_value;
  logic        freeze_btn;
  logic [7:0]  out_0, out_1, out_2, out_3, out_4, out_5, out_6, out_7;
  logic [7:0]  changed;
  logic        snap_valid;
  logic [1:0]  state;
  logic [63:0] out_vec;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] outs;
    logic [7:0]  chg;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  assign out_vec = {out_7, out_6, out_5, out_4, out_3, out_2, out_1, out_0};

  probe_capture #(.SAMPLE_DIV(8), .DEBOUNCE(4), .HOLD_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn), .probe(probe), .mode(mode), .trig_ch(trig_ch),
    .trig_mask(trig_mask), .trig_value(trig_value), .freeze_btn(freeze_btn),
    .out_0(out_0), .out_1(out_1), .out_2(out_2), .out_3(out_3),
    .out_4(out_4), .out_5(out_5), .out_6(out_6), .out_7(out_7),
    .changed(changed), .snap_valid(snap_valid), .state(state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (resetn && snap_valid) begin
      $display("snap t=%0t out=%h changed=%h", $time, out_vec, changed);
      check("snap_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("snap_out", out_vec, e.outs);
        check("snap_changed", 64'(changed), 64'(e.chg));
      end
    end
  end

  initial begin
    int n;
    int first;
    probe = P0; mode = 1'b0; trig_ch = 3'd0; trig_mask = 8'h00; trig_value = 8'h00;
    freeze_btn = 1'b1; resetn = 1'b0;
    tick(3);
    check("rst_out", out_vec, 64'd0);
    check("rst_changed", 64'(changed), 64'd0);
    check("rst_snap", 64'(snap_valid), 64'd0);
    check("rst_state", 64'(state), 64'(ST_RUN));

    // Free-run: first snapshot 8 cycles after release, then every 8.
    resetn = 1'b1;
    exp_q.push_back('{P0, 8'hFE});
    tick(7); check("fr_no_early_snap", 64'(snap_valid), 64'd0);
    tick(1); check("fr_first_snap", 64'(snap_valid), 64'd1);
    check("fr_out3", 64'(out_3), 64'h03);
    exp_q.push_back('{P0, 8'h00});
    tick(7); check("fr_gap", 64'(snap_valid), 64'd0);
    tick(1); check("fr_second_snap", 64'(snap_valid), 64'd1);

    // Trigger on channel 2 upper nibble == A.
    trig_ch = 3'd2; trig_mask = 8'hF0; trig_value = 8'hA0; mode = 1'b1; probe = P1;
    tick(3); check("arm_state", 64'(state), 64'(ST_ARMED));
    probe = P2;
    exp_q.push_back('{P2, 8'h04});
    tick(1); check("trig_wait_probe_q", 64'(snap_valid), 64'd0);
    tick(1); check("trig_snap", 64'(snap_valid), 64'd1);
    check("trig_out2", 64'(out_2), 64'hA7);
    check("hold_state", 64'(state), 64'(ST_HOLD));
    n = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (state == ST_HOLD) n++;
    end
    check("hold_len", 64'(n), 64'd15);
    exp_q.push_back('{P2, 8'h00});
    tick(1); check("hold_to_armed", 64'(state), 64'(ST_ARMED));
    tick(1); check("retrig_snap", 64'(snap_valid), 64'd1);

    // Asynchronous reset in the middle of HOLD.
    tick(3); check("pre_rst_state", 64'(state), 64'(ST_HOLD));
    resetn = 1'b0;
    #1;
    check("arst_out", out_vec, 64'd0);
    check("arst_changed", 64'(changed), 64'd0);
    check("arst_state", 64'(state), 64'(ST_RUN));
    mode = 1'b0; probe = P0;
    tick(2);
    resetn = 1'b1;
    exp_q.push_back('{P0, 8'hFE});
    tick(8); check("post_rst_snap", 64'(snap_valid), 64'd1);

    // Press accepted in the cycle the divider wraps: freeze wins, no snapshot.
    tick(1);
    freeze_btn = 1'b0;
    tick(6); check("press_pending", 64'(state), 64'(ST_RUN));
    tick(1); check("freeze_state", 64'(state), 64'(ST_FROZEN));
    check("freeze_no_snap", 64'(snap_valid), 64'd0);
    check("freeze_out_held", out_vec, P0);
    probe = P3; freeze_btn = 1'b1;
    tick(12);
    check("frozen_out_held", out_vec, P0);
    check("release_no_action", 64'(state), 64'(ST_FROZEN));

    // Second press leaves to RUN; first snapshot 8 cycles later.
    freeze_btn = 1'b0;
    exp_q.push_back('{P3, 8'h7F});
    tick(6); check("unfreeze_pending", 64'(state), 64'(ST_FROZEN));
    tick(1); check("unfreeze_state", 64'(state), 64'(ST_RUN));
    tick(7); check("unfreeze_gap", 64'(snap_valid), 64'd0);
    tick(1); check("unfreeze_snap", 64'(snap_valid), 64'd1);

    // Bounce test in ARMED with an unmatchable trigger so no snapshots occur.
    mode = 1'b1; trig_ch = 3'd0; trig_mask = 8'hFF; trig_value = 8'h55; freeze_btn = 1'b1;
    tick(2); check("bounce_armed", 64'(state), 64'(ST_ARMED));
    tick(8);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      freeze_btn = ((i / 2) % 2) == 1;
      tick(1);
      if (state == ST_FROZEN) n++;
    end
    check("bounce_no_freeze", 64'(n), 64'd0);
    freeze_btn = 1'b0;
    first = -1;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      if (state == ST_FROZEN && first < 0) first = i;
    end
    check("bounce_accept_time", 64'(first), 64'd7);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (state == ST_FROZEN) n++;
    end
    check("bounce_single_press", 64'(n), 64'd20);
    freeze_btn = 1'b1;
    tick(10);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
